// File: rtl/wow_sample_pkg.sv
// Shared types and constants for the sample-memory fetch path.
// Used by the arbiter and its round-robin picker.
package wow_sample_pkg;

  localparam int SAMPLE_AW = 24;
  localparam int SAMPLE_DW = 16;
  localparam int SAMPLE_CH = 4;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  typedef logic [SAMPLE_AW-1:0] sample_addr_t;
  typedef logic [SAMPLE_DW-1:0] sample_word_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: first set request after 'last',
// wrapping modulo N.
module rr_pick
  import wow_sample_pkg::*;
#(
  parameter int N  = SAMPLE_CH,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] win,
  output logic          valid
);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % N);
      if (req[cand]) begin
        win   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_fetch_arbiter.sv
// Shares the sample-memory read port among NUM_CH voices,
// one read outstanding, round-robin grant, bounded wait.
module sample_fetch_arbiter
  import wow_sample_pkg::*;
#(
  parameter int NUM_CH  = SAMPLE_CH,
  parameter int AW      = SAMPLE_AW,
  parameter int DW      = SAMPLE_DW,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              I_RESET_L,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH*AW-1:0] ch_addr,
  output logic [NUM_CH-1:0] ch_ack,
  output logic [DW-1:0]     ch_data,
  output logic [AW-1:0]     s_addr,
  output logic              s_read,
  input  logic [DW-1:0]     s_data,
  input  logic              s_ready,
  output logic              busy,
  output logic              timeout_err
);

  localparam int IW = idx_w(NUM_CH);
  localparam logic [7:0] TMAX = 8'(TIMEOUT);

  state_t        state;
  logic [IW-1:0] grant;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] win;
  logic          any;
  logic [7:0]    timer;

  rr_pick #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_pick (
    .req   (ch_req),
    .last  (last_grant),
    .win   (win),
    .valid (any)
  );

  assign busy = (state == WAIT);

  always_ff @(posedge CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= IW'(NUM_CH - 1);
      timer       <= '0;
      ch_ack      <= '0;
      ch_data     <= '0;
      s_addr      <= '0;
      s_read      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ch_ack <= '0;
      unique case (state)
        IDLE: begin
          if (any) begin
            grant  <= win;
            s_addr <= ch_addr[win*AW +: AW];
            s_read <= 1'b1;
            timer  <= '0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (s_ready) begin
            ch_data       <= s_data;
            ch_ack[grant] <= 1'b1;
            s_read        <= 1'b0;
            last_grant    <= grant;
            state         <= IDLE;
          end else if (timer == TMAX) begin
            // Give up so the voice is released with a silent word.
            ch_data       <= '0;
            ch_ack[grant] <= 1'b1;
            s_read        <= 1'b0;
            timeout_err   <= 1'b1;
            last_grant    <= grant;
            state         <= IDLE;
          end else if (timer != 8'hFF) begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_fetch_arbiter.sv
// Directed bench for sample_fetch_arbiter: grant order, latency,
// timeout, async reset, spurious ready, fairness.
module tb_sample_fetch_arbiter;
  import wow_sample_pkg::*;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 16;

  logic            CLK = 1'b0;
  logic            I_RESET_L = 1'b0;
  logic [N-1:0]    ch_req = '0;
  logic [N*AW-1:0] ch_addr = '0;
  logic [N-1:0]    ch_ack;
  logic [DW-1:0]   ch_data;
  logic [AW-1:0]   s_addr;
  logic            s_read;
  logic [DW-1:0]   s_data = '0;
  logic            s_ready = 1'b0;
  logic            busy;
  logic            timeout_err;

  sample_fetch_arbiter #(
    .NUM_CH  (N),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (255)
  ) dut (
    .CLK         (CLK),
    .I_RESET_L   (I_RESET_L),
    .ch_req      (ch_req),
    .ch_addr     (ch_addr),
    .ch_ack      (ch_ack),
    .ch_data     (ch_data),
    .s_addr      (s_addr),
    .s_read      (s_read),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit auto_mem = 1'b0;
  int lat      = 2;
  int lat_cnt  = 0;
  logic [AW-1:0] addr_v [N];

  function automatic logic [15:0] mem_word(input logic [23:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One cycle; optional memory model answers lat cycles after s_read.
  task automatic tick();
    @(negedge CLK);
    if (auto_mem) begin
      if (s_ready) begin
        s_ready = 1'b0;
        lat_cnt = 0;
      end else if (s_read) begin
        lat_cnt++;
        if (lat_cnt >= lat) begin
          s_ready = 1'b1;
          s_data  = mem_word(s_addr);
          lat_cnt = 0;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  endtask

  task automatic wait_ack(input int bound, output logic [N-1:0] got);
    got = '0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (ch_ack != '0) begin
        got = ch_ack;
        break;
      end
    end
  endtask

  task automatic do_reset();
    I_RESET_L = 1'b0;
    ch_req    = '0;
    s_ready   = 1'b0;
    auto_mem  = 1'b0;
    lat_cnt   = 0;
    repeat (2) @(negedge CLK);
    I_RESET_L = 1'b1;
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] got;
    int acks;
    int idx;
    int arbs;
    bit found3;

    addr_v[0] = 24'h000100;
    addr_v[1] = 24'h001234;
    addr_v[2] = 24'hABC002;
    addr_v[3] = 24'h7FFFF3;
    for (int i = 0; i < N; i++) ch_addr[i*AW +: AW] = addr_v[i];

    // Reset values
    @(negedge CLK);
    check_eq("rst_ack",  ch_ack, 0);
    check_eq("rst_data", ch_data, 0);
    check_eq("rst_addr", s_addr, 0);
    check_eq("rst_read", s_read, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_terr", timeout_err, 0);
    I_RESET_L = 1'b1;

    // Single request, 3-cycle memory
    tick();
    ch_req = 4'b0010;
    tick();
    check_eq("t1_read",  s_read, 1);
    check_eq("t1_addr",  s_addr, 24'h001234);
    check_eq("t1_busy",  busy, 1);
    tick();
    ch_addr[1*AW +: AW] = 24'hFFFFFF;
    tick();
    check_eq("t1_addr_hold", s_addr, 24'h001234);
    check_eq("t1_no_ack", ch_ack, 0);
    s_ready = 1'b1;
    s_data  = 16'hBEEF;
    tick();
    s_ready = 1'b0;
    ch_req  = '0;
    ch_addr[1*AW +: AW] = addr_v[1];
    check_eq("t1_ack",   ch_ack, 4'b0010);
    check_eq("t1_data",  ch_data, 16'hBEEF);
    check_eq("t1_read_lo", s_read, 0);
    check_eq("t1_idle",  busy, 0);
    tick();
    check_eq("t1_ack_pulse", ch_ack, 0);

    // All channels continuously, 2-cycle memory
    do_reset();
    auto_mem = 1'b1;
    lat      = 2;
    ch_req   = 4'b1111;
    acks     = 0;
    for (int c = 0; c < 200 && acks < 6; c++) begin
      tick();
      if (ch_ack != '0) begin
        check_eq("t2_onehot", $countones(ch_ack), 1);
        idx = 0;
        for (int i = 0; i < N; i++) if (ch_ack[i]) idx = i;
        check_eq("t2_order", idx, acks % N);
        check_eq("t2_data", ch_data, mem_word(addr_v[acks % N]));
        check_eq("t2_gap", s_read, 0);
        acks++;
      end
    end
    ch_req = '0;
    check_eq("t2_count", acks, 6);
    repeat (3) tick();
    auto_mem = 1'b0;

    // Timeout with no s_ready
    ch_req = 4'b0100;
    repeat (256) tick();
    check_eq("t3_pre_ack",  ch_ack, 0);
    check_eq("t3_pre_busy", busy, 1);
    check_eq("t3_pre_terr", timeout_err, 0);
    tick();
    ch_req = '0;
    check_eq("t3_ack",  ch_ack, 4'b0100);
    check_eq("t3_data", ch_data, 0);
    check_eq("t3_terr", timeout_err, 1);
    check_eq("t3_busy", busy, 0);
    auto_mem = 1'b1;
    lat      = 1;
    ch_req   = 4'b0001;
    wait_ack(20, got);
    ch_req   = '0;
    auto_mem = 1'b0;
    check_eq("t3_next_ack",  got, 4'b0001);
    check_eq("t3_next_data", ch_data, mem_word(addr_v[0]));
    check_eq("t3_sticky",    timeout_err, 1);

    // Spurious s_ready in IDLE
    tick();
    s_ready = 1'b1;
    s_data  = 16'h5555;
    tick();
    s_ready = 1'b0;
    check_eq("t5_ack",  ch_ack, 0);
    check_eq("t5_data", ch_data, mem_word(addr_v[0]));
    check_eq("t5_busy", busy, 0);
    tick();
    check_eq("t5_ack2", ch_ack, 0);
    check_eq("t5_read", s_read, 0);

    // Async reset mid-WAIT, then late s_ready
    ch_req = 4'b0001;
    tick();
    check_eq("t4_read", s_read, 1);
    tick();
    #2;
    I_RESET_L = 1'b0;
    ch_req    = '0;
    #1;
    check_eq("t4_read_lo", s_read, 0);
    check_eq("t4_busy",    busy, 0);
    check_eq("t4_terr",    timeout_err, 0);
    check_eq("t4_data",    ch_data, 0);
    check_eq("t4_addr",    s_addr, 0);
    check_eq("t4_ack",     ch_ack, 0);
    @(negedge CLK);
    I_RESET_L = 1'b1;
    tick();
    s_ready = 1'b1;
    s_data  = 16'h1111;
    tick();
    s_ready = 1'b0;
    check_eq("t4_late_ack",  ch_ack, 0);
    check_eq("t4_late_busy", busy, 0);
    tick();
    check_eq("t4_late_ack2", ch_ack, 0);
    check_eq("t4_late_data", ch_data, 0);

    // Fairness: ch0 hogging, ch3 raises once
    do_reset();
    auto_mem = 1'b1;
    lat      = 2;
    ch_req   = 4'b0001;
    wait_ack(20, got);
    check_eq("t6_first", got, 4'b0001);
    ch_req = 4'b1001;
    arbs   = 0;
    found3 = 1'b0;
    for (int a = 0; a < 2 && !found3; a++) begin
      wait_ack(20, got);
      arbs++;
      if (got == 4'b1000) begin
        found3 = 1'b1;
        ch_req = 4'b0001;
      end
    end
    check_eq("t6_ch3_by_2nd", found3, 1);
    check_eq("t6_ch3_data", ch_data, mem_word(addr_v[3]));
    wait_ack(20, got);
    ch_req = '0;
    check_eq("t6_back_ch0", got, 4'b0001);
    repeat (3) tick();
    auto_mem = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
